// File: rtl/step_ctl.sv
// Run/halt/single-step controller gating the CPU clock enable.
// Optional cycle counter: define STEP_CTL_CYCLE_COUNT_EN.
module step_ctl #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic pulse,
    input  logic run,
    input  logic step_btn,
    input  logic hlt,
    output logic cpu_en,
    output logic running,
    output logic armed
`ifdef STEP_CTL_CYCLE_COUNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        HALT  = 2'd0,
        RUN   = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam logic [15:0] DEB_MAX = 16'(DEB_CYCLES - 1);

    state_t      state;
    logic        run_q1;
    logic        run_s;
    logic        step_q1;
    logic        step_s;
    logic        step_deb;
    logic [15:0] deb_cnt;
    logic        step_req;

    // Two-flop synchronisers for the asynchronous switch and button
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            run_q1  <= 1'b0;
            run_s   <= 1'b0;
            step_q1 <= 1'b0;
            step_s  <= 1'b0;
        end else begin
            run_q1  <= run;
            run_s   <= run_q1;
            step_q1 <= step_btn;
            step_s  <= step_q1;
        end
    end

    // Accept a new button level only after it has held for DEB_CYCLES
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            step_deb <= 1'b0;
            deb_cnt  <= '0;
        end else if (step_s == step_deb) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_MAX) begin
            step_deb <= step_s;
            deb_cnt  <= '0;
        end else begin
            deb_cnt <= deb_cnt + 16'd1;
        end
    end

    // One-cycle request on the accepted press only, never on release
    assign step_req = step_s && !step_deb && (deb_cnt == DEB_MAX);

    // Mode FSM with registered enable and status outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= HALT;
            cpu_en  <= 1'b0;
            running <= 1'b0;
            armed   <= 1'b0;
        end else begin
            cpu_en <= 1'b0;
            unique case (state)
                HALT: begin
                    if (run_s && !hlt) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (step_req) begin
                        state <= ARMED;
                        armed <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run_s || hlt) begin
                        state   <= HALT;
                        running <= 1'b0;
                    end else begin
                        cpu_en <= pulse;
                    end
                end
                ARMED: begin
                    cpu_en <= pulse;
                    if (run_s && !hlt) begin
                        state   <= RUN;
                        running <= 1'b1;
                        armed   <= 1'b0;
                    end else if (pulse) begin
                        state <= HALT;
                        armed <= 1'b0;
                    end
                end
                default: begin
                    state   <= HALT;
                    running <= 1'b0;
                    armed   <= 1'b0;
                end
            endcase
        end
    end

`ifdef STEP_CTL_CYCLE_COUNT_EN
    // Count issued enables, wrapping at the counter width
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cycle_cnt <= '0;
        end else if (cpu_en) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_step_ctl.sv
// Directed bench for step_ctl with DEB_CYCLES=4, CNT_W=4.
// Counter checks apply when STEP_CTL_CYCLE_COUNT_EN is defined.
module tb_step_ctl;

    logic       clk = 1'b0;
    logic       nrst;
    logic       pulse;
    logic       run;
    logic       step_btn;
    logic       hlt;
    logic       cpu_en;
    logic       running;
    logic       armed;
`ifdef STEP_CTL_CYCLE_COUNT_EN
    logic [3:0] cycle_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt = 0;
    int n_en;

    step_ctl #(
        .DEB_CYCLES(4),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .pulse(pulse),
        .run(run),
        .step_btn(step_btn),
        .hlt(hlt),
        .cpu_en(cpu_en),
        .running(running),
        .armed(armed)
`ifdef STEP_CTL_CYCLE_COUNT_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse in a mode that must pass it through; 4-cycle spacing
    task automatic run_pulse();
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        chk("en_hi", cpu_en, 1);
        exp_cnt++;
        tick();
        chk("en_lo", cpu_en, 0);
`ifdef STEP_CTL_CYCLE_COUNT_EN
        chk("cnt", cycle_cnt, exp_cnt % 16);
`endif
        tick(2);
    endtask

    initial begin
        nrst = 1'b0;
        pulse = 1'b0;
        run = 1'b1;
        step_btn = 1'b0;
        hlt = 1'b0;

        // Reset with run high and pulses arriving
        tick();
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        chk("rst_en", cpu_en, 0);
        chk("rst_run", running, 0);
        chk("rst_arm", armed, 0);
`ifdef STEP_CTL_CYCLE_COUNT_EN
        chk("rst_cnt", cycle_cnt, 0);
`endif
        nrst = 1'b1;
        tick(2);
        chk("run_e2", running, 0);
        tick();
        chk("run_e3", running, 1);
        for (int i = 0; i < 10; i++) run_pulse();
`ifdef STEP_CTL_CYCLE_COUNT_EN
        chk("cnt10", cycle_cnt, 10);
`endif

        // hlt with pulse on the same cycle
        pulse = 1'b1;
        hlt = 1'b1;
        tick();
        pulse = 1'b0;
        chk("hlt_en", cpu_en, 0);
        chk("hlt_run", running, 0);
        tick(2);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        chk("hlt_en2", cpu_en, 0);
        tick();
        chk("hlt_en3", cpu_en, 0);
        hlt = 1'b0;
        tick();
        chk("hlt_rel", running, 1);

        // Leave RUN via the switch: 3 edges
        run = 1'b0;
        tick(2);
        chk("stop_e2", running, 1);
        tick();
        chk("stop_e3", running, 0);
        tick(2);

        // Bouncing press 1-0-1 then stable
        step_btn = 1'b1;
        tick();
        step_btn = 1'b0;
        tick();
        step_btn = 1'b1;
        tick();
        tick(4);
        chk("deb_early", armed, 0);
        tick();
        chk("deb_arm", armed, 1);
        tick(3);
        chk("arm_hold", armed, 1);
        chk("arm_noen", cpu_en, 0);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        chk("step_en", cpu_en, 1);
        chk("step_halt", armed, 0);
        exp_cnt++;
        tick();
        chk("step_en1", cpu_en, 0);
        n_en = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) pulse = 1'b1;
            tick();
            pulse = 1'b0;
            n_en += int'(cpu_en) + int'(armed);
        end
        step_btn = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i % 4 == 0) pulse = 1'b1;
            tick();
            pulse = 1'b0;
            n_en += int'(cpu_en) + int'(armed);
        end
        chk("hold_rel", n_en, 0);

        // ARMED, run_s rises on the same edge as pulse
        step_btn = 1'b1;
        tick(5);
        chk("arm2_pre", armed, 0);
        tick();
        chk("arm2", armed, 1);
        run = 1'b1;
        tick(2);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        chk("a2r_en", cpu_en, 1);
        chk("a2r_run", running, 1);
        chk("a2r_arm", armed, 0);
        exp_cnt++;
        tick(3);

        // Continued enables, counter wrap at 4 bits
        while (exp_cnt < 17) run_pulse();
`ifdef STEP_CTL_CYCLE_COUNT_EN
        chk("cnt_wrap", cycle_cnt, 1);
`endif

        // Reset while ARMED, one cycle before pulse
        run = 1'b0;
        step_btn = 1'b0;
        tick(3);
        chk("halt2", running, 0);
        tick(8);
        step_btn = 1'b1;
        tick(6);
        chk("arm3", armed, 1);
        nrst = 1'b0;
        step_btn = 1'b0;
        #1;
        chk("async_arm", armed, 0);
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        nrst = 1'b1;
        chk("rst_en2", cpu_en, 0);
        tick();
        chk("post_en", cpu_en, 0);
        chk("post_arm", armed, 0);
        chk("post_run", running, 0);
`ifdef STEP_CTL_CYCLE_COUNT_EN
        chk("post_cnt", cycle_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/step_ctl.md
# step_ctl

Run/halt/single-step controller sitting directly downstream of the pulse generator. Consumes its one-cycle `pulse` strobe and emits the CPU clock enable `cpu_en`, gated by a run switch, a debounced step button and the CPU halt line. It provides free-run, single-step and halt-on-`hlt` operation for bring-up.

## Interface
- `DEB_CYCLES`, default 16: consecutive stable cycles required to accept a new step-button level; legal range 2..65535.
- `CNT_W`, default 16: width of `cycle_cnt`.
- `clk`  in  1  system clock, all logic on rising edge.
- `nrst`  in  1  reset, asynchronous, active-low; asynchronous assertion, synchronous to `clk` release assumed.
- `pulse`  in  1  synchronous one-cycle strobe from the pulse generator.
- `run`  in  1  raw run switch, asynchronous; 2-FF synchronised internally to `run_s`.
- `step_btn`  in  1  raw step button, asynchronous; 2-FF synchronised, then debounced.
- `hlt`  in  1  synchronous CPU halt request, level.
- `cpu_en`  out  1  registered one-cycle CPU clock enable.
- `running`  out  1  high in RUN.
- `armed`  out  1  high in ARMED.
- `cycle_cnt`  out  `CNT_W`  count of issued `cpu_en` cycles; present only with the configuration macro.

## Operation
- Reset values: state HALT, sync flops 0, debounced step 0, debounce counter 0, `cpu_en`/`running`/`armed` 0, `cycle_cnt` 0.
- Debounce: counter clears whenever the synced button equals the debounced level. Otherwise it increments. On the cycle the counter equals `DEB_CYCLES-1` and the levels still differ, the debounced level takes the synced value and the counter clears. `step_req` is the 0→1 update event of the debounced level: exactly one cycle per accepted press. Releases produce no request.
- States and transitions, evaluated each edge, first match wins:
  - HALT: `run_s`=1 and `hlt`=0 → RUN; else `step_req` → ARMED; else stay.
  - RUN: `run_s`=0 or `hlt`=1 → HALT; else stay. `step_req` is ignored.
  - ARMED: `run_s`=1 and `hlt`=0 → RUN; else `pulse` → HALT; else stay. Further `step_req` is ignored, not queued.
- Enable: `cpu_en` is set on the next edge when `pulse`=1 and either (state RUN and not exiting this edge) or (state ARMED). Otherwise `cpu_en` is 0.
- Simultaneous events:
  - RUN exit coinciding with `pulse`: pulse is suppressed.
  - ARMED with `pulse` and a transition to RUN on the same edge: pulse is honoured.
  - `hlt` does not block the armed step; single-stepping past `hlt` is allowed.
- Reset mid-operation clears all state at once. A pending armed step and any in-flight `cpu_en` are discarded.

## Timing
- `pulse` → `cpu_en`: 1 cycle latency, width exactly 1 cycle; one `cpu_en` per qualifying `pulse`, never more.
- `run` edge → state change: 3 edges (2 sync + 1 state).
- Step press → ARMED: 2 sync edges + `DEB_CYCLES` edges of stability. Any bounce restarts the count.
- `hlt` → HALT: 1 edge. A `pulse` in the same cycle as `hlt` yields no `cpu_en`.
- `running`/`armed` are decoded from registered state with no extra latency.

## Configuration
- `STEP_CTL_CYCLE_COUNT_EN`:
  - Defined: `cycle_cnt` port and counter exist. The counter increments by 1 on every cycle `cpu_en`=1 and wraps from 2^`CNT_W`-1 to 0.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Reset with `run`=1 and pulses every 4 cycles: outputs 0 during reset. After release, `running`=1 at edge 3. `cpu_en` follows each subsequent `pulse` by 1 cycle; 10 pulses give 10 enables and `cycle_cnt`=10.
- `DEB_CYCLES`=4, step press bouncing 1-0-1 then stable 1: exactly one ARMED entry. Next `pulse` gives a single `cpu_en`, then HALT. A 20-cycle hold and the release produce no further enable.
- RUN, assert `hlt` on the same cycle as `pulse`: no `cpu_en`, state HALT next edge. Later pulses give no enable while `hlt`=1.
- ARMED with `run` synced high on the same edge as `pulse`: one `cpu_en`, state RUN, continued enables.
- `CNT_W`=4, 17 enables: `cycle_cnt` reads 15 after 15 enables, then 0, then 1.
- Assert `nrst` while ARMED one cycle before `pulse`: no `cpu_en`, state HALT, `armed`=0 after release.
